// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder
//   Captures event pulses into a sticky pending register. The lowest-index
//   pending bit is presented on a valid/ready output stage, and each bit is
//   cleared once the consumer accepts it. The block sits between event
//   sources and a consumer that is not always ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   clr        synchronous clear of the pending register and the output stage
//   en         capture enable; req is ignored while low
//   req[N]     event inputs (multi-hot allowed), sampled on every edge
//   out_idx    encoded index of the request being served
//   out_valid  out_idx holds a valid index
//   out_ready  consumer accepts; a transfer is out_valid & out_ready
//   pending[N] sticky pending register, exposed for observability
//   overflow   one-cycle pulse: an event hit a bit that was already pending
//              and was not being served in that cycle
module pending_priority_encoder #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx_n;
    logic             valid_n;
    logic [N-1:0]     pend_n;
    logic             ovf_n;

    logic             xfer;
    logic [N-1:0]     served;
    logic [N-1:0]     cap;
    logic [N-1:0]     rem;

    // Lowest set index wins. Scanning from the top down lets the last hit,
    // which is the lowest index, overwrite the result.
    function automatic logic [IDX_W-1:0] enc(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign xfer   = out_valid & out_ready;
    assign served = xfer ? ({{(N-1){1'b0}}, 1'b1} << out_idx) : '0;
    assign cap    = en ? req : '0;
    // Bits captured on this edge are excluded here. They are only
    // considered once they are visible in pending, in the next cycle.
    assign rem    = pending & ~served;

    always_comb begin
        state_n = state;
        idx_n   = out_idx;
        valid_n = out_valid;
        // Serving a bit and re-requesting it in the same cycle keeps the bit
        // set. That case is not an overflow, because the old event was consumed.
        pend_n  = rem | cap;
        ovf_n   = |(cap & rem);

        case (state)
            IDLE: begin
                if (|pending) begin
                    idx_n   = enc(pending);
                    valid_n = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // Hold the index stable until it is accepted. A newly arrived
                // lower index never pre-empts the one already presented.
                if (xfer) begin
                    if (|rem) begin
                        idx_n = enc(rem);
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase

        // clr overrides capture and serving. A transfer already under way in
        // this cycle still completes from the consumer's side.
        if (clr) begin
            pend_n  = '0;
            valid_n = 1'b0;
            ovf_n   = 1'b0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pend_n;
            out_idx   <= idx_n;
            out_valid <= valid_n;
            overflow  <= ovf_n;
        end
    end

endmodule
